// File: rtl/nco_pkg.sv
// Shared widths, timing constants and state encoding for the NCO frequency sweep controller.
// Pure declarations: no latency, no flow control.
package nco_pkg;

    localparam int WORD_W     = 13;
    localparam int DWELL_W    = 16;
    localparam int SETTLE_CYC = 4;
    localparam int ACC_W      = DWELL_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        PROG,
        SETTLE,
        DWELL,
        EVAL,
        STEP,
        DONE
    } state_t;

endpackage

// File: rtl/sign_corr_acc.sv
// Signed I/Q sign-agreement integrators with |I|+|Q| output; one cycle per sample, mag is combinational.
// No backpressure: en samples every cycle it is high, clear has priority over en.
module sign_corr_acc
    import nco_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    input  logic             i_code,
    input  logic             q_code,
    input  logic             rx_bit,
    output logic [ACC_W-1:0] mag
);

    localparam logic signed [ACC_W-1:0] PLUS_ONE  = {{(ACC_W-1){1'b0}}, 1'b1};
    localparam logic signed [ACC_W-1:0] MINUS_ONE = {ACC_W{1'b1}};

    logic signed [ACC_W-1:0] acc_i;
    logic signed [ACC_W-1:0] acc_q;
    logic        [ACC_W-1:0] abs_i;
    logic        [ACC_W-1:0] abs_q;
    logic        [ACC_W:0]   sum;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            acc_i <= '0;
            acc_q <= '0;
        end else if (en) begin
            acc_i <= acc_i + ((rx_bit == i_code) ? PLUS_ONE : MINUS_ONE);
            acc_q <= acc_q + ((rx_bit == q_code) ? PLUS_ONE : MINUS_ONE);
        end
    end

    always_comb begin
        abs_i = acc_i[ACC_W-1] ? ACC_W'(-acc_i) : ACC_W'(acc_i);
        abs_q = acc_q[ACC_W-1] ? ACC_W'(-acc_q) : ACC_W'(acc_q);
        sum   = {1'b0, abs_i} + {1'b0, abs_q};
        mag   = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
    end

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Steps the NCO word from f_start to f_stop, correlating each point; dwell+7 cycles per point.
// No backpressure: start is ignored while busy, abort returns to IDLE at once.
module nco_sweep_ctrl
    import nco_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] f_start,
    input  logic [WORD_W-1:0] f_stop,
    input  logic [WORD_W-1:0] f_step,
    input  logic [DWELL_W-1:0] dwell_len,
    input  logic              i_code,
    input  logic              q_code,
    input  logic              rx_bit,
    output logic [WORD_W-1:0] nco_word,
    output logic              nco_rst,
    output logic              busy,
    output logic              pt_valid,
    output logic [WORD_W-1:0] pt_word,
    output logic [ACC_W-1:0]  pt_mag,
    output logic [WORD_W-1:0] best_word,
    output logic [ACC_W-1:0]  best_mag,
    output logic              done
);

    localparam logic [DWELL_W-1:0] SETTLE_LAST = DWELL_W'(SETTLE_CYC - 1);

    state_t               state;
    state_t               state_nxt;
    logic [WORD_W-1:0]    f_stop_l;
    logic [WORD_W-1:0]    f_step_l;
    logic [DWELL_W-1:0]   dwell_l;
    logic [DWELL_W-1:0]   cnt;
    logic [DWELL_W-1:0]   dwell_last;
    logic [WORD_W:0]      nxt;
    logic                 last_pt;
    logic                 accept;
    logic [ACC_W-1:0]     mag;

    sign_corr_acc u_acc (
        .clk    (clk),
        .rst    (rst),
        .clear  (state == PROG),
        .en     (state == DWELL),
        .i_code (i_code),
        .q_code (q_code),
        .rx_bit (rx_bit),
        .mag    (mag)
    );

    // A zero dwell length still integrates one sample.
    assign dwell_last = (dwell_l == '0) ? '0 : dwell_l - DWELL_W'(1);
    // Carry bit catches steps that would wrap past the top of the word range.
    assign nxt        = {1'b0, nco_word} + {1'b0, f_step_l};
    assign last_pt    = (f_step_l == '0) || nxt[WORD_W] || (nxt[WORD_W-1:0] > f_stop_l);
    assign accept     = (state == IDLE) && start && !abort;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = PROG;
            PROG:    state_nxt = SETTLE;
            SETTLE:  if (cnt == SETTLE_LAST) state_nxt = DWELL;
            DWELL:   if (cnt == dwell_last) state_nxt = EVAL;
            EVAL:    state_nxt = STEP;
            STEP:    state_nxt = last_pt ? DONE : PROG;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    assign nco_rst = (state == IDLE) || (state == PROG) || (state == DONE);
    assign done    = (state == DONE) && !abort;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            f_stop_l  <= '0;
            f_step_l  <= '0;
            dwell_l   <= '0;
            nco_word  <= '0;
            busy      <= 1'b0;
            pt_valid  <= 1'b0;
            pt_word   <= '0;
            pt_mag    <= '0;
            best_word <= '0;
            best_mag  <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= (state_nxt != state) ? '0 : cnt + DWELL_W'(1);
            pt_valid <= 1'b0;
            if (accept) begin
                f_stop_l  <= f_stop;
                f_step_l  <= f_step;
                dwell_l   <= dwell_len;
                nco_word  <= f_start;
                best_word <= f_start;
                best_mag  <= '0;
                busy      <= 1'b1;
            end
            // pt_valid trails EVAL by one cycle so it lines up with registered pt_word/pt_mag.
            if (!abort && state == EVAL) begin
                pt_valid <= 1'b1;
                pt_word  <= nco_word;
                pt_mag   <= mag;
                if (mag > best_mag) begin
                    best_mag  <= mag;
                    best_word <= nco_word;
                end
            end
            if (!abort && state == STEP && !last_pt) nco_word <= nxt[WORD_W-1:0];
            if (abort || state == DONE) busy <= 1'b0;
        end
    end

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Directed bench for nco_sweep_ctrl: expected points are queued at stimulus time and
// checked by an independent monitor on every pt_valid.
module tb_nco_sweep_ctrl;
    import nco_pkg::*;

    logic               clk;
    logic               rst;
    logic               start;
    logic               abort;
    logic [WORD_W-1:0]  f_start;
    logic [WORD_W-1:0]  f_stop;
    logic [WORD_W-1:0]  f_step;
    logic [DWELL_W-1:0] dwell_len;
    logic               i_code;
    logic               q_code;
    logic               rx_bit;
    logic [WORD_W-1:0]  nco_word;
    logic               nco_rst;
    logic               busy;
    logic               pt_valid;
    logic [WORD_W-1:0]  pt_word;
    logic [ACC_W-1:0]   pt_mag;
    logic [WORD_W-1:0]  best_word;
    logic [ACC_W-1:0]   best_mag;
    logic               done;

    logic rx_mode;
    logic rx_const;
    logic tog;

    typedef struct {
        int word;
        int mag;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec    = 0;
    int   n_miss   = 0;
    int   done_cnt = 0;

    nco_sweep_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .f_start   (f_start),
        .f_stop    (f_stop),
        .f_step    (f_step),
        .dwell_len (dwell_len),
        .i_code    (i_code),
        .q_code    (q_code),
        .rx_bit    (rx_bit),
        .nco_word  (nco_word),
        .nco_rst   (nco_rst),
        .busy      (busy),
        .pt_valid  (pt_valid),
        .pt_word   (pt_word),
        .pt_mag    (pt_mag),
        .best_word (best_word),
        .best_mag  (best_mag),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) tog <= ~tog;

    // Mode 1: perfect agreement only while the word is 300, alternating (zero-mean) elsewhere.
    assign rx_bit = rx_mode ? ((nco_word == 13'd300) ? 1'b0 : tog) : rx_const;

    task automatic chk(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (pt_valid) begin
                if (exp_q.size() == 0) begin
                    chk("pt_valid_unexpected", int'(pt_valid), 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("pt_word", int'(pt_word), e.word);
                    chk("pt_mag", int'(pt_mag), e.mag);
                end
            end
            if (done) done_cnt++;
        end
    end

    task automatic push(input int w, input int m);
        exp_t e;
        e.word = w;
        e.mag  = m;
        exp_q.push_back(e);
    endtask

    task automatic do_start(input int fs, input int fe, input int fp, input int dw);
        @(posedge clk); #1;
        f_start   = WORD_W'(fs);
        f_stop    = WORD_W'(fe);
        f_step    = WORD_W'(fp);
        dwell_len = DWELL_W'(dw);
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    task automatic finish_sweep(input string tag, input int d0, input int bw, input int bm);
        bit seen = 0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
        end
        chk({tag, "_done_seen"}, int'(seen), 1);
        repeat (2) @(negedge clk);
        chk({tag, "_done_count"}, done_cnt - d0, 1);
        chk({tag, "_points_left"}, exp_q.size(), 0);
        chk({tag, "_best_word"}, int'(best_word), bw);
        chk({tag, "_best_mag"}, int'(best_mag), bm);
        chk({tag, "_busy_after"}, int'(busy), 0);
        chk({tag, "_nco_rst_idle"}, int'(nco_rst), 1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_nco_word"}, int'(nco_word), 0);
        chk({tag, "_nco_rst"}, int'(nco_rst), 1);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_pt_valid"}, int'(pt_valid), 0);
        chk({tag, "_pt_word"}, int'(pt_word), 0);
        chk({tag, "_pt_mag"}, int'(pt_mag), 0);
        chk({tag, "_best_word"}, int'(best_word), 0);
        chk({tag, "_best_mag"}, int'(best_mag), 0);
        chk({tag, "_done"}, int'(done), 0);
    endtask

    initial begin
        int  d0;
        bit  hit;
        tog       = 1'b0;
        rst       = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        f_start   = '0;
        f_stop    = '0;
        f_step    = '0;
        dwell_len = '0;
        i_code    = 1'b0;
        q_code    = 1'b0;
        rx_mode   = 1'b0;
        rx_const  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        rst = 1'b0;

        // Four points, all agreeing: 64+64 each, tie keeps the first word.
        d0 = done_cnt;
        push(100, 128); push(200, 128); push(300, 128); push(400, 128);
        do_start(100, 400, 100, 64);
        finish_sweep("sweep4", d0, 100, 128);

        // Only word 300 correlates; first point (mag 0) is provisional best.
        rx_mode = 1'b1;
        d0 = done_cnt;
        push(100, 0); push(200, 0); push(300, 128); push(400, 0);
        do_start(100, 400, 100, 64);
        finish_sweep("peak300", d0, 300, 128);
        rx_mode = 1'b0;

        // 8000+500 overflows 13 bits: one point only.
        d0 = done_cnt;
        push(8000, 20);
        do_start(8000, 8191, 500, 10);
        finish_sweep("carry", d0, 8000, 20);

        // I disagrees every cycle (I=-5), Q agrees (Q=+5): |I|+|Q| = 10; zero step.
        i_code = 1'b1;
        d0 = done_cnt;
        push(50, 10);
        do_start(50, 1000, 0, 5);
        finish_sweep("step0", d0, 50, 10);

        d0 = done_cnt;
        push(500, 6);
        do_start(500, 200, 100, 3);
        finish_sweep("start_gt_stop", d0, 500, 6);

        d0 = done_cnt;
        push(7, 2);
        do_start(7, 7, 1, 0);
        finish_sweep("dwell0", d0, 7, 2);
        i_code = 1'b0;

        // Abort in the dwell of the second point.
        d0 = done_cnt;
        push(100, 128);
        do_start(100, 400, 100, 64);
        hit = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (nco_word == 13'd200) begin
                hit = 1;
                break;
            end
        end
        chk("abort_reach_pt2", int'(hit), 1);
        repeat (15) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_nco_rst", int'(nco_rst), 1);
        chk("abort_done", int'(done), 0);
        repeat (100) @(negedge clk);
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_points_left", exp_q.size(), 0);
        chk("abort_best_word", int'(best_word), 100);
        chk("abort_best_mag", int'(best_mag), 128);

        // Synchronous reset in the middle of a sweep.
        do_start(100, 400, 100, 64);
        repeat (30) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        chk_reset_vals("midrst");
        rst = 1'b0;

        // Second start while busy must not disturb the running sweep.
        d0 = done_cnt;
        push(100, 16); push(200, 16); push(300, 16);
        do_start(100, 300, 100, 8);
        repeat (20) @(posedge clk);
        do_start(1000, 2000, 1, 2);
        finish_sweep("start_busy", d0, 100, 16);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
